// File: rtl/systolic_feed_ctrl_pkg.sv
// Shared types and constants for the systolic array feed sequencer.
// Holds the FSM state encoding plus the default array and lane sizes.
package systolic_feed_ctrl_pkg;

  localparam int N_DEFAULT    = 4;
  localparam int LANE_WIDTH   = 8;
  localparam int FLUSH_CYCLES = 2 * N_DEFAULT;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_FLUSH,
    ST_DONE
  } state_t;

  // Cycles needed for the last skewed wavefront to cross an n x n grid.
  function automatic int flush_cycles(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/systolic_feed_ctrl_skew.sv
// Zero-reset shift register delaying one lane by DEPTH cycles.
// DEPTH=0 collapses to a wire so lane 0 needs no special case upstream.
module skew_delay_line
  import systolic_feed_ctrl_pkg::*;
#(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = LANE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ctrl;
      assign unused_ctrl = clk ^ rst_n;
      assign dout        = din;
    end else begin : g_shift
      logic [DATA_WIDTH-1:0] stage_reg [DEPTH];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int si = 0; si < DEPTH; si++) stage_reg[si] <= '0;
        end else begin
          stage_reg[0] <= din;
          for (int si = 1; si < DEPTH; si++) stage_reg[si] <= stage_reg[si-1];
        end
      end

      assign dout = stage_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Sequencer that clears, feeds and drains an N x N output-stationary systolic array.
// Operands are read K times, then skewed so lane i enters the grid i cycles late.
module systolic_feed_ctrl
  import systolic_feed_ctrl_pkg::*;
#(
  parameter int N          = N_DEFAULT,
  parameter int DATA_WIDTH = LANE_WIDTH,
  parameter int K_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [K_WIDTH-1:0]      k_len,
  output logic                    busy,
  output logic                    done,
  output logic                    results_valid,
  output logic                    array_clr,
  output logic                    rd_en,
  output logic [K_WIDTH-1:0]      rd_addr,
  input  logic [N*DATA_WIDTH-1:0] a_rd_data,
  input  logic [N*DATA_WIDTH-1:0] b_rd_data,
  output logic [N*DATA_WIDTH-1:0] west_bus,
  output logic [N*DATA_WIDTH-1:0] north_bus
);

  localparam int FLUSH_LEN = flush_cycles(N);
  localparam int CNT_W     = $clog2(FLUSH_LEN) + 1;

  state_t             state_reg;
  logic [K_WIDTH-1:0] k_reg;
  logic [K_WIDTH-1:0] rd_addr_reg;
  logic [CNT_W-1:0]   flush_cnt_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               results_valid_reg;
  logic               array_clr_reg;
  logic               rd_en_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg         <= ST_IDLE;
      k_reg             <= '0;
      rd_addr_reg       <= '0;
      flush_cnt_reg     <= '0;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
      results_valid_reg <= 1'b0;
      array_clr_reg     <= 1'b0;
      rd_en_reg         <= 1'b0;
    end else begin
      done_reg      <= 1'b0;
      array_clr_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            k_reg             <= k_len;
            results_valid_reg <= 1'b0;
            busy_reg          <= 1'b1;
            array_clr_reg     <= 1'b1;
            state_reg         <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (k_reg == '0) begin
            flush_cnt_reg <= '0;
            state_reg     <= ST_FLUSH;
          end else begin
            rd_en_reg   <= 1'b1;
            rd_addr_reg <= '0;
            state_reg   <= ST_FEED;
          end
        end
        ST_FEED: begin
          // rd_addr stays at K-1 afterwards; the buffer ignores it while rd_en is low.
          if (rd_addr_reg == k_reg - K_WIDTH'(1)) begin
            rd_en_reg     <= 1'b0;
            flush_cnt_reg <= '0;
            state_reg     <= ST_FLUSH;
          end else begin
            rd_addr_reg <= rd_addr_reg + K_WIDTH'(1);
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_reg == CNT_W'(FLUSH_LEN - 1)) begin
            done_reg          <= 1'b1;
            results_valid_reg <= 1'b1;
            state_reg         <= ST_DONE;
          end else begin
            flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
          end
        end
        ST_DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Read data is valid one cycle after the strobe; non-valid cycles capture
  // zeros so the grid only ever sees bubbles outside the data window.
  logic                    valid_reg;
  logic [N*DATA_WIDTH-1:0] a_cap_reg;
  logic [N*DATA_WIDTH-1:0] b_cap_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      a_cap_reg <= '0;
      b_cap_reg <= '0;
    end else begin
      valid_reg <= rd_en_reg;
      a_cap_reg <= valid_reg ? a_rd_data : '0;
      b_cap_reg <= valid_reg ? b_rd_data : '0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      skew_delay_line #(.DEPTH(gi), .DATA_WIDTH(DATA_WIDTH)) u_west (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (a_cap_reg[gi*DATA_WIDTH +: DATA_WIDTH]),
        .dout  (west_bus[gi*DATA_WIDTH +: DATA_WIDTH])
      );
      skew_delay_line #(.DEPTH(gi), .DATA_WIDTH(DATA_WIDTH)) u_north (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (b_cap_reg[gi*DATA_WIDTH +: DATA_WIDTH]),
        .dout  (north_bus[gi*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

  assign busy          = busy_reg;
  assign done          = done_reg;
  assign results_valid = results_valid_reg;
  assign array_clr     = array_clr_reg;
  assign rd_en         = rd_en_reg;
  assign rd_addr       = rd_addr_reg;

endmodule
